instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; begin fetching from IDLE.
- halt  in  1  level; stop after the current instruction handshake.
- pc_in  in  16  current PC, from the program-counter register's data_out.
- pc_inc  out  1  one-cycle pulse to the PC register's inc.
- pc_load  out  1  one-cycle pulse to the PC register's load_enable.
- pc_load_val  out  16  value for the PC register's data_in.
- jump_req  in  1  redirect request; sampled every cycle.
- jump_addr  in  16  redirect target.
- mem_rd  out  1  instruction-memory read strobe.
- mem_addr  out  16  read address.
- mem_rdata  in  16  read data; valid when mem_ack=1.
- mem_ack  in  1  read-complete pulse; arrives 1 or more cycles after mem_rd.
- ir_out  out  16  fetched instruction to decode.
- ir_pc  out  16  address ir_out was fetched from.
- ir_valid  out  1  ir_out/ir_pc valid.
- ir_ready  in  1  decode accepts; a transfer occurs when ir_valid & ir_ready.
- fetch_count  out  16  number of instructions transferred to decode.

Function
REQ-002 The FSM SHALL have exactly the states IDLE, REQ, WAIT, DRAIN and VALID.
REQ-003 IDLE: when start=1, the FSM SHALL go to REQ; otherwise it SHALL stay in IDLE.
REQ-004 REQ: for exactly one cycle, mem_rd=1 and mem_addr=pc_in; the address SHALL be latched internally, and the FSM SHALL go to WAIT.
REQ-005 WAIT: on mem_ack=1 with jump_req=0, the block SHALL:
- load ir_out with mem_rdata;
- load ir_pc with the latched address;
- pulse pc_inc for that same cycle;
- go to VALID.
REQ-006 VALID: ir_valid SHALL be 1; ir_out and ir_pc SHALL stay stable until the transfer.
REQ-007 On a transfer, the block SHALL:
- increment fetch_count (mod 2^16);
- go to IDLE if halt=1, otherwise go to REQ.
REQ-008 ir_valid SHALL be 0 in every state other than VALID.
REQ-009 pc_inc and pc_load SHALL never be asserted in the same cycle.
REQ-010 A jump in any state other than IDLE SHALL pulse pc_load=1 for one cycle with pc_load_val=jump_addr; jump_req SHALL have priority over mem_ack and over a transfer.
REQ-011 Jump in REQ: mem_rd SHALL still assert for that cycle, and the FSM SHALL go to DRAIN.
REQ-012 Jump in WAIT with mem_ack=0: the FSM SHALL go to DRAIN.
REQ-013 Jump in WAIT with mem_ack=1: the read data SHALL be discarded, pc_inc SHALL NOT pulse, and the FSM SHALL go to REQ.
REQ-014 Jump in VALID: the instruction SHALL be discarded even if ir_ready=1, fetch_count SHALL be unchanged, and the FSM SHALL go to REQ.
REQ-015 DRAIN: the block SHALL wait for mem_ack, discard the data without pulsing pc_inc, then go to REQ; a further jump_req in DRAIN SHALL pulse pc_load again and remain in DRAIN.
REQ-016 jump_req in IDLE SHALL be ignored, with no pc_load pulse.
REQ-017 The REQ cycle following a pc_inc or pc_load SHALL use the updated pc_in, since the PC register updates on the same edge.
REQ-018 When pc_load=0, pc_load_val SHALL be 0.
REQ-019 When mem_rd=0, mem_addr SHALL hold its last value.
REQ-020 fetch_count SHALL wrap from 0xFFFF to 0x0000.
REQ-021 halt SHALL be ignored except at a transfer in VALID.

Reset
REQ-022 While reset=0, asynchronously:
- state SHALL be IDLE;
- ir_out, ir_pc, mem_addr, pc_load_val and fetch_count SHALL be 0;
- mem_rd, pc_inc, pc_load and ir_valid SHALL be 0.
REQ-023 Reset asserted mid-fetch (REQ, WAIT or DRAIN) SHALL abandon the read; a mem_ack arriving after reset is released while in IDLE SHALL be ignored.
REQ-024 After reset is released, no output SHALL change until start=1.

Verification
REQ-025 Basic fetch: pc_in=0x0010, start=1, mem_ack 2 cycles after mem_rd with rdata=0xABCD, ir_ready=1 -> mem_addr=0x0010; one pc_inc pulse; ir_out=0xABCD, ir_pc=0x0010; fetch_count=1.
REQ-026 Backpressure: ir_ready=0 for 5 cycles -> ir_valid held, ir_out stable, no new mem_rd; transfer occurs on the first cycle ir_ready=1.
REQ-027 Jump during WAIT: jump_req=1, jump_addr=0x0200 before mem_ack -> one pc_load with pc_load_val=0x0200; the late ack is discarded; next mem_addr=0x0200; no pc_inc for the dropped fetch.
REQ-028 Simultaneous events: jump_req and mem_ack in the same cycle -> pc_load=1, pc_inc=0, ir_valid stays 0; in VALID, jump_req with ir_ready=1 -> fetch_count unchanged.
REQ-029 Halt and wrap: fetch_count preset to 0xFFFF via 65535 transfers, halt=1 at the next transfer -> fetch_count=0x0000, FSM in IDLE, mem_rd stays 0.
REQ-030 Reset mid-fetch: reset=0 while in WAIT -> all outputs 0 immediately; mem_ack after release with start=0 -> ir_valid stays 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads one instruction word per request from
// instruction memory, hands it to decode, and steers the PC register.
//
// state | meaning
// IDLE  | stopped; waits for start
// REQ   | one-cycle memory read strobe at pc_in
// WAIT  | read in flight, data will be kept
// DRAIN | read in flight after a redirect, data will be dropped
// VALID | instruction offered to decode
module instr_fetch #(
  parameter logic [15:0] FETCH_COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [15:0] pc_in,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [15:0] pc_load_val,
  input  logic        jump_req,
  input  logic [15:0] jump_addr,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] ir_out,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] fetch_count
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, VALID} state_t;

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] ir_q;
  logic [15:0] ir_pc_q;
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ir_q    <= '0;
      ir_pc_q <= '0;
      count_q <= FETCH_COUNT_INIT;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= REQ;
        REQ: begin
          addr_q  <= pc_in;
          state_q <= jump_req ? DRAIN : WAIT;
        end
        WAIT: begin
          if (jump_req) begin
            state_q <= mem_ack ? REQ : DRAIN;
          end else if (mem_ack) begin
            ir_q    <= mem_rdata;
            ir_pc_q <= addr_q;
            state_q <= VALID;
          end
        end
        // An ack together with a new jump still retires the stale read; the
        // jump itself has already been applied through pc_load.
        DRAIN: if (mem_ack) state_q <= REQ;
        VALID: begin
          if (jump_req) begin
            state_q <= REQ;
          end else if (ir_ready) begin
            count_q <= count_q + 16'd1;
            state_q <= halt ? IDLE : REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // PC strobes act within the cycle so the following REQ sees the new PC.
  assign mem_rd      = (state_q == REQ);
  assign mem_addr    = mem_rd ? pc_in : addr_q;
  assign pc_load     = jump_req && (state_q != IDLE);
  assign pc_load_val = pc_load ? jump_addr : 16'h0000;
  assign pc_inc      = (state_q == WAIT) && mem_ack && !jump_req;
  assign ir_valid    = (state_q == VALID);
  assign ir_out      = ir_q;
  assign ir_pc       = ir_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run, all
// checked every cycle against a transaction-level fetch model.
module tb_instr_fetch;

  localparam logic [15:0] WRAP_INIT = 16'hFFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, halt = 1'b0, jump_req = 1'b0, mem_ack = 1'b0, ir_ready = 1'b0;
  logic [15:0] pc_in = '0, jump_addr = '0, mem_rdata = '0;
  logic        pc_inc, pc_load, mem_rd, ir_valid;
  logic [15:0] pc_load_val, mem_addr, ir_out, ir_pc, fetch_count;
  logic        w_pc_inc, w_pc_load, w_mem_rd, w_ir_valid;
  logic [15:0] w_pc_load_val, w_mem_addr, w_ir_out, w_ir_pc, w_fetch_count;

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pc_in(pc_in),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .jump_req(jump_req), .jump_addr(jump_addr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir_out(ir_out), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_count(fetch_count)
  );

  // Same stimulus, counter starting near the top so wraparound is reachable.
  instr_fetch #(.FETCH_COUNT_INIT(WRAP_INIT)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pc_in(pc_in),
    .pc_inc(w_pc_inc), .pc_load(w_pc_load), .pc_load_val(w_pc_load_val),
    .jump_req(jump_req), .jump_addr(jump_addr), .mem_rd(w_mem_rd), .mem_addr(w_mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir_out(w_ir_out), .ir_pc(w_ir_pc),
    .ir_valid(w_ir_valid), .ir_ready(ir_ready), .fetch_count(w_fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // drive values for the next cycle
  logic        drv_rst = 1'b0, drv_start = 1'b0, drv_halt = 1'b0, drv_jump = 1'b0, drv_ready = 1'b0;
  logic [15:0] drv_jaddr = '0;
  logic        fixed_en = 1'b0;
  logic [15:0] fixed_data = '0;
  int          ack_dly = 0;  // 0 = random 1..3 cycles
  logic        ack_pend = 1'b0;
  int          ack_cnt = 0;
  logic [15:0] pc_next = '0;

  // transaction-level model of the fetcher
  logic        m_running, m_need_req, m_outstanding, m_keep, m_hold;
  logic [15:0] m_addr, m_ir, m_irpc, m_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_running = 0; m_need_req = 0; m_outstanding = 0; m_keep = 0; m_hold = 0;
    m_addr = '0; m_ir = '0; m_irpc = '0; m_cnt = '0;
  endtask

  task automatic step();
    logic        e_rd, e_load, e_inc, e_valid;
    logic [15:0] e_addr, e_lval, e_ir, e_irpc, e_cnt;
    @(negedge clk);
    pc_in     = pc_next;
    reset     = drv_rst;
    start     = drv_start;
    halt      = drv_halt;
    jump_req  = drv_jump;
    jump_addr = drv_jaddr;
    ir_ready  = drv_ready;
    mem_rdata = fixed_en ? fixed_data : 16'($urandom);
    if (ack_pend && ack_cnt == 1) begin
      mem_ack = 1'b1; ack_pend = 1'b0;
    end else begin
      mem_ack = 1'b0;
      if (ack_pend) ack_cnt--;
    end
    #1;
    if (!reset) begin
      model_clear();
      e_rd = 0; e_addr = '0; e_load = 0; e_lval = '0; e_inc = 0;
      e_valid = 0; e_ir = '0; e_irpc = '0; e_cnt = '0;
    end else begin
      e_rd    = m_need_req;
      e_addr  = m_need_req ? pc_in : m_addr;
      e_load  = jump_req && m_running;
      e_lval  = e_load ? jump_addr : 16'h0000;
      e_inc   = m_outstanding && m_keep && mem_ack && !jump_req;
      e_valid = m_hold;
      e_ir    = m_ir;
      e_irpc  = m_irpc;
      e_cnt   = m_cnt;
    end
    chk("mem_rd", mem_rd, e_rd);
    chk("mem_addr", mem_addr, e_addr);
    chk("pc_load", pc_load, e_load);
    chk("pc_load_val", pc_load_val, e_lval);
    chk("pc_inc", pc_inc, e_inc);
    chk("ir_valid", ir_valid, e_valid);
    chk("ir_out", ir_out, e_ir);
    chk("ir_pc", ir_pc, e_irpc);
    chk("fetch_count", fetch_count, e_cnt);
    chk("wrap_fetch_count", w_fetch_count, e_cnt + WRAP_INIT);
    if (reset) begin
      if (!m_running) begin
        if (start) begin m_running = 1; m_need_req = 1; end
      end else if (m_need_req) begin
        m_addr = pc_in; m_need_req = 0; m_outstanding = 1; m_keep = !jump_req;
      end else if (m_outstanding) begin
        if (mem_ack) begin
          m_outstanding = 0;
          if (m_keep && !jump_req) begin
            m_hold = 1; m_ir = mem_rdata; m_irpc = m_addr;
          end else m_need_req = 1;
        end else if (jump_req) m_keep = 0;
      end else if (m_hold) begin
        if (jump_req) begin
          m_hold = 0; m_need_req = 1;
        end else if (ir_ready) begin
          m_hold = 0; m_cnt = m_cnt + 16'd1;
          if (halt) m_running = 0; else m_need_req = 1;
        end
      end
    end
    // environment: memory responder and PC register
    if (reset && mem_rd) begin
      ack_pend = 1'b1;
      ack_cnt  = (ack_dly == 0) ? int'($urandom_range(1, 3)) : ack_dly;
    end
    pc_next = pc_load ? pc_load_val : (pc_inc ? pc_in + 16'd1 : pc_in);
  endtask

  task automatic step_until_valid(input string name);
    int n = 0;
    while (!ir_valid && n < 20) begin step(); n++; end
    if (!ir_valid) begin
      total++; bad++;
      $display("FAIL %s timeout actual=ir_valid 0 required=ir_valid 1", name);
    end
  endtask

  initial begin
    model_clear();
    drv_rst = 0;
    repeat (2) step();
    drv_rst = 1;
    step();
    chk("rst_fetch_count", fetch_count, 16'h0000);
    chk("rst_ir_out", ir_out, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ir_valid", ir_valid, 1'b0);
    drv_jump = 1; drv_jaddr = 16'h4444;
    step();
    chk("idle_jump_pc_load", pc_load, 1'b0);
    chk("idle_jump_val", pc_load_val, 16'h0000);
    drv_jump = 0;

    // basic fetch
    pc_next = 16'h0010; fixed_en = 1; fixed_data = 16'hABCD; ack_dly = 2;
    drv_start = 1; drv_halt = 1; drv_ready = 1;
    step();
    step();
    chk("basic_mem_rd", mem_rd, 1'b1);
    chk("basic_mem_addr", mem_addr, 16'h0010);
    drv_start = 0;
    step();
    step();
    chk("basic_pc_inc", pc_inc, 1'b1);
    step();
    chk("basic_ir_valid", ir_valid, 1'b1);
    chk("basic_ir_out", ir_out, 16'hABCD);
    chk("basic_ir_pc", ir_pc, 16'h0010);
    step();
    chk("basic_count", fetch_count, 16'h0001);
    chk("basic_idle_rd", mem_rd, 1'b0);

    // backpressure
    fixed_data = 16'h1357; ack_dly = 1;
    drv_start = 1; drv_halt = 0; drv_ready = 0;
    step_until_valid("bp_reach_valid");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_valid", ir_valid, 1'b1);
      chk("bp_no_rd", mem_rd, 1'b0);
      chk("bp_ir_out", ir_out, 16'h1357);
      chk("bp_ir_pc", ir_pc, 16'h0011);
    end
    drv_ready = 1; drv_halt = 1; drv_start = 0;
    step();
    step();
    chk("bp_count", fetch_count, 16'h0002);

    // jump while waiting for data
    fixed_en = 0; ack_dly = 3;
    drv_start = 1; drv_halt = 0;
    step();
    step();
    drv_start = 0;
    drv_jump = 1; drv_jaddr = 16'h0200;
    step();
    chk("jw_pc_load", pc_load, 1'b1);
    chk("jw_pc_load_val", pc_load_val, 16'h0200);
    chk("jw_pc_inc", pc_inc, 1'b0);
    drv_jump = 0;
    step();
    ack_dly = 1;
    step();
    chk("jw_late_ack_no_inc", pc_inc, 1'b0);
    step();
    chk("jw_next_addr", mem_addr, 16'h0200);
    chk("jw_next_rd", mem_rd, 1'b1);

    // jump coincident with ack, then jump coincident with a transfer
    drv_jump = 1; drv_jaddr = 16'h0300;
    step();
    chk("sim_pc_load", pc_load, 1'b1);
    chk("sim_pc_inc", pc_inc, 1'b0);
    drv_jump = 0;
    step();
    chk("sim_no_valid", ir_valid, 1'b0);
    chk("sim_addr", mem_addr, 16'h0300);
    step();
    drv_jump = 1; drv_jaddr = 16'h0400;
    step();
    chk("sim_valid_jump", ir_valid, 1'b1);
    drv_jump = 0; ack_dly = 3;
    step();
    chk("sim_count_same", fetch_count, 16'h0002);
    chk("sim_addr2", mem_addr, 16'h0400);

    // reset while a read is in flight
    drv_jump = 1; drv_jaddr = 16'h0500;
    step();
    drv_jump = 0;
    reset = 0; drv_rst = 0;
    #1;
    model_clear();
    chk("rm_mem_rd", mem_rd, 1'b0);
    chk("rm_mem_addr", mem_addr, 16'h0000);
    chk("rm_pc_load", pc_load, 1'b0);
    chk("rm_pc_load_val", pc_load_val, 16'h0000);
    chk("rm_pc_inc", pc_inc, 1'b0);
    chk("rm_ir_valid", ir_valid, 1'b0);
    chk("rm_ir_out", ir_out, 16'h0000);
    chk("rm_ir_pc", ir_pc, 16'h0000);
    chk("rm_fetch_count", fetch_count, 16'h0000);
    drv_rst = 1; drv_start = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rm_ack_ignored", ir_valid, 1'b0);
    end

    // wrap of the preset counter together with halt
    ack_dly = 0; drv_start = 1; drv_ready = 1; drv_halt = 0;
    for (int n = 0; n < 400 && m_cnt < 16'd16; n++) begin
      drv_halt = (m_cnt == 16'd15);
      step();
    end
    drv_start = 0; drv_halt = 0;
    step();
    chk("wrap_count", w_fetch_count, 16'h0000);
    chk("wrap_main_count", fetch_count, 16'h0010);
    chk("wrap_idle_valid", w_ir_valid, 1'b0);
    chk("wrap_idle_rd", w_mem_rd, 1'b0);
    step();
    chk("wrap_still_no_rd", w_mem_rd, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drv_start = ($urandom_range(0, 9) != 0);
      drv_halt  = ($urandom_range(0, 9) == 0);
      drv_jump  = ($urandom_range(0, 9) == 0);
      drv_ready = ($urandom_range(0, 9) < 7);
      drv_jaddr = 16'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
